// File: rtl/hack_mux_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hack_mux_pkg
// Purpose  : Shared definitions for the Hack arbitrating multiplexer family.
//            - sel_width(): width of a channel index (clog2, minimum 1)
//            - hack_hs_t  : valid/ready handshake pair
// Revision : 1.0  initial release
// ============================================================================
package hack_mux_pkg;

  typedef struct packed {
    logic valid;
    logic ready;
  } hack_hs_t;

  // ceil(log2(n)) but never less than 1, so a 2-way mux still has a 1-bit index
  function automatic int sel_width(input int n);
    int w;
    w = 1;
    for (int k = 1; k < 31; k++) begin
      if ((1 << k) < n) w = k + 1;
    end
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hack_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : hack_rr_arbiter
// Purpose  : Combinational round-robin arbiter. Grants the first requester
//            found searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
// Ports    : req[N]        request vector
//            ptr           search start index (0..N-1)
//            grant[N]      one-hot grant (all zero when no request)
//            grant_idx     index of the granted channel (0 when none)
//            any           at least one request present
// Revision : 1.0  initial release
// ============================================================================
module hack_rr_arbiter
  import hack_mux_pkg::*;
#(
  parameter  int N    = 4,
  localparam int SELW = sel_width(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [SELW-1:0] grant_idx,
  output logic            any
);

  always_comb begin
    int   w_start;
    int   w_idx;
    logic w_found;
    grant     = '0;
    grant_idx = '0;
    w_found   = 1'b0;
    w_idx     = 0;
    // An out-of-range pointer (only reachable for non-power-of-two N) falls
    // back to channel 0 rather than skipping the search.
    w_start   = (int'(ptr) < N) ? int'(ptr) : 0;
    for (int k = 0; k < N; k++) begin
      w_idx = w_start + k;
      if (w_idx >= N) w_idx = w_idx - N;
      if (!w_found && req[w_idx]) begin
        w_found          = 1'b1;
        grant[w_idx]     = 1'b1;
        grant_idx        = SELW'(w_idx);
      end
    end
    any = w_found;
  end

endmodule
`default_nettype wire

// File: rtl/hack_arb_mux.sv
`default_nettype none
// ============================================================================
// Module   : hack_arb_mux
// Purpose  : N-way, W-bit round-robin arbitrating multiplexer with
//            valid/ready on every input and a registered output stage.
// Ports    : clk, rst (async, active-high)
//            in_data[N*W]  channel i at [i*W +: W]
//            in_valid[N]   / in_ready[N]  per-channel handshake
//            out_data[W], out_valid, out_ready, out_sel[SELW]
// Options  : HACK_ARB_MUX_FORCE_EN adds force_en / force_sel, which restrict
//            the grant to one channel without moving the round-robin pointer.
// Revision : 1.0  initial release
// ============================================================================
module hack_arb_mux
  import hack_mux_pkg::*;
#(
  parameter  int W    = 16,
  parameter  int N    = 4,
  localparam int SELW = sel_width(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N*W-1:0]  in_data,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
  output logic [W-1:0]    out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SELW-1:0] out_sel
`ifdef HACK_ARB_MUX_FORCE_EN
  ,
  input  logic            force_en,
  input  logic [SELW-1:0] force_sel
`endif
);

  logic [W-1:0]    r_out_data;
  logic [SELW-1:0] r_out_sel;
  logic            r_out_valid;
  logic [SELW-1:0] r_ptr;

  logic [N-1:0]    w_req;
  logic [N-1:0]    w_grant;
  logic [SELW-1:0] w_grant_idx;
  logic            w_any;
  logic            w_load;
  logic            w_accept;
  logic            w_ptr_upd;
  logic [SELW-1:0] w_ptr_next;
  logic [W-1:0]    w_sel_data;
  logic [W-1:0]    w_slice [N];
  hack_hs_t        w_out_hs;

`ifdef HACK_ARB_MUX_FORCE_EN
  // Forcing masks the request vector down to the selected channel; an index
  // of N or more matches no channel and therefore grants nothing.
  always_comb begin
    w_req = in_valid;
    if (force_en) begin
      w_req = '0;
      for (int i = 0; i < N; i++) begin
        if (int'(force_sel) == i) w_req[i] = in_valid[i];
      end
    end
  end
  assign w_ptr_upd = ~force_en;
`else
  assign w_req     = in_valid;
  assign w_ptr_upd = 1'b1;
`endif

  hack_rr_arbiter #(.N(N)) u_arb (
    .req       (w_req),
    .ptr       (r_ptr),
    .grant     (w_grant),
    .grant_idx (w_grant_idx),
    .any       (w_any)
  );

  assign w_out_hs.valid = r_out_valid;
  assign w_out_hs.ready = out_ready;

  // Register is empty or being drained this cycle, so it can take a new word
  assign w_load   = ~w_out_hs.valid | w_out_hs.ready;
  assign w_accept = w_any & w_load;

  // rst gating keeps in_ready low during an asynchronous reset even though
  // the emptied register would otherwise report load=1.
  assign in_ready = w_grant & {N{w_load & ~rst}};

  // AND-OR select: grant is one-hot, so at most one slice is non-zero
  for (genvar gi = 0; gi < N; gi++) begin : g_sel
    assign w_slice[gi] = in_data[gi*W +: W] & {W{w_grant[gi]}};
  end

  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < N; i++) w_sel_data = w_sel_data | w_slice[i];
  end

  // Explicit wrap so non-power-of-two N never leaves the pointer at N
  assign w_ptr_next = (w_grant_idx == SELW'(N - 1)) ? '0 : w_grant_idx + SELW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_data  <= '0;
      r_out_sel   <= '0;
      r_out_valid <= 1'b0;
      r_ptr       <= '0;
    end else if (w_accept) begin
      r_out_data  <= w_sel_data;
      r_out_sel   <= w_grant_idx;
      r_out_valid <= 1'b1;
      if (w_ptr_upd) r_ptr <= w_ptr_next;
    end else if (w_load) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;
  assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_hack_arb_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_hack_arb_mux
// Purpose  : Self-checking bench for hack_arb_mux: directed vector table,
//            hand-written reset/fairness/wrap sequences, and randomized
//            traffic against a behavioural model of the arbitration rules.
// Revision : 1.0  initial release
// ============================================================================
module tb_hack_arb_mux;

  logic        clk;
  logic        rst;
  logic [63:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_sel;

  logic [23:0] d3_in_data;
  logic [2:0]  d3_in_valid;
  logic [2:0]  d3_in_ready;
  logic [7:0]  d3_out_data;
  logic        d3_out_valid;
  logic        d3_out_ready;
  logic [1:0]  d3_out_sel;

`ifdef HACK_ARB_MUX_FORCE_EN
  logic        f_en;
  logic [1:0]  f_sel;
  logic        f3_en;
  logic [1:0]  f3_sel;
`endif

  int checks = 0;
  int errors = 0;

  hack_arb_mux #(.W(16), .N(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sel   (out_sel)
`ifdef HACK_ARB_MUX_FORCE_EN
    ,
    .force_en  (f_en),
    .force_sel (f_sel)
`endif
  );

  hack_arb_mux #(.W(8), .N(3)) dut3 (
    .clk       (clk),
    .rst       (rst),
    .in_data   (d3_in_data),
    .in_valid  (d3_in_valid),
    .in_ready  (d3_in_ready),
    .out_data  (d3_out_data),
    .out_valid (d3_out_valid),
    .out_ready (d3_out_ready),
    .out_sel   (d3_out_sel)
`ifdef HACK_ARB_MUX_FORCE_EN
    ,
    .force_en  (f3_en),
    .force_sel (f3_sel)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  vld;
    logic [63:0] data;
    logic        ordy;
    logic [3:0]  rdy;
    logic        ov;
    logic [15:0] od;
    logic [1:0]  os;
  } vec_t;

  vec_t tbl [12];

  // Behavioural model state
  int          m_ptr;
  logic        m_valid;
  logic [15:0] m_data;
  int          m_sel;

  function automatic logic [3:0] model_ready(input logic [3:0] vld, input logic ordy);
    int g;
    g = -1;
    for (int k = 0; k < 4; k++) begin
      if (g < 0 && vld[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
    end
    if (g >= 0 && (!m_valid || ordy)) return 4'(1 << g);
    return 4'b0;
  endfunction

  task automatic model_step(input logic [3:0] vld, input logic [63:0] data, input logic ordy);
    logic [3:0] r;
    r = model_ready(vld, ordy);
    if (r != 0) begin
      for (int g = 0; g < 4; g++) begin
        if (r[g]) begin
          m_data  = data[g*16 +: 16];
          m_sel   = g;
          m_valid = 1'b1;
          m_ptr   = (g + 1) % 4;
        end
      end
    end else if (!m_valid || ordy) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    m_ptr = 0; m_valid = 1'b0; m_data = '0; m_sel = 0;
  endtask

  initial begin
    logic [63:0] d4;
    logic [3:0]  pend;
    logic [3:0]  er;
    d4 = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
    tbl[0]  = '{4'b0100, {16'h0, 16'hBEEF, 16'h0, 16'h0}, 1'b1, 4'b0100, 1'b1, 16'hBEEF, 2'd2};
    tbl[1]  = '{4'b1111, d4, 1'b1, 4'b1000, 1'b1, 16'h1003, 2'd3};
    tbl[2]  = '{4'b1111, d4, 1'b1, 4'b0001, 1'b1, 16'h1000, 2'd0};
    tbl[3]  = '{4'b1111, d4, 1'b1, 4'b0010, 1'b1, 16'h1001, 2'd1};
    tbl[4]  = '{4'b1111, d4, 1'b1, 4'b0100, 1'b1, 16'h1002, 2'd2};
    tbl[5]  = '{4'b1111, d4, 1'b0, 4'b0000, 1'b1, 16'h1002, 2'd2};
    tbl[6]  = '{4'b1111, d4, 1'b0, 4'b0000, 1'b1, 16'h1002, 2'd2};
    tbl[7]  = '{4'b1111, d4, 1'b0, 4'b0000, 1'b1, 16'h1002, 2'd2};
    tbl[8]  = '{4'b1111, d4, 1'b1, 4'b1000, 1'b1, 16'h1003, 2'd3};
    tbl[9]  = '{4'b0000, d4, 1'b1, 4'b0000, 1'b0, 16'h1003, 2'd3};
    tbl[10] = '{4'b0000, d4, 1'b0, 4'b0000, 1'b0, 16'h1003, 2'd3};
    tbl[11] = '{4'b0001, d4, 1'b0, 4'b0001, 1'b1, 16'h1000, 2'd0};

    rst = 1'b1;
    in_data = '0; in_valid = '0; out_ready = 1'b0;
    d3_in_data = '0; d3_in_valid = '0; d3_out_ready = 1'b0;
`ifdef HACK_ARB_MUX_FORCE_EN
    f_en = 1'b0; f_sel = '0; f3_en = 1'b0; f3_sel = '0;
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_data",  64'(out_data),  64'd0);
    chk("reset_out_sel",   64'(out_sel),   64'd0);

    // Directed table: single source, fairness order, backpressure, drain
    for (int i = 0; i < 12; i++) begin
      in_valid  = tbl[i].vld;
      in_data   = tbl[i].data;
      out_ready = tbl[i].ordy;
      #3;
      chk($sformatf("tbl%0d_in_ready", i), 64'(in_ready), 64'(tbl[i].rdy));
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_out_valid", i), 64'(out_valid), 64'(tbl[i].ov));
      chk($sformatf("tbl%0d_out_data", i),  64'(out_data),  64'(tbl[i].od));
      chk($sformatf("tbl%0d_out_sel", i),   64'(out_sel),   64'(tbl[i].os));
    end

    // Asynchronous reset in mid-cycle while holding a word
    in_valid  = 4'b1111;
    out_ready = 1'b0;
    #3 rst = 1'b1;
    #1;
    chk("async_rst_out_valid", 64'(out_valid), 64'd0);
    chk("async_rst_out_data",  64'(out_data),  64'd0);
    chk("async_rst_out_sel",   64'(out_sel),   64'd0);
    chk("async_rst_in_ready",  64'(in_ready),  64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // First grant after reset goes to channel 0, then strict rotation
    out_ready = 1'b1;
    #3;
    chk("post_rst_in_ready", 64'(in_ready), 64'b0001);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("rotation%0d_out_sel", k), 64'(out_sel), 64'(k % 4));
      chk($sformatf("rotation%0d_out_data", k), 64'(out_data), 64'(16'h1000 + 16'(k % 4)));
    end
    in_valid = '0;

    // N=3: move ptr to 2 via channel 1, then channels 0 and 2 alternate
    d3_in_data   = {8'hC2, 8'hC1, 8'hC0};
    d3_out_ready = 1'b1;
    d3_in_valid  = 3'b010;
    #3;
    chk("n3_setup_in_ready", 64'(d3_in_ready), 64'b010);
    @(posedge clk);
    #1;
    chk("n3_setup_out_sel", 64'(d3_out_sel), 64'd1);
    d3_in_valid = 3'b101;
    for (int k = 0; k < 4; k++) begin
      #3;
      chk($sformatf("n3_wrap%0d_in_ready", k), 64'(d3_in_ready), (k % 2 == 0) ? 64'b100 : 64'b001);
      @(posedge clk);
      #1;
      chk($sformatf("n3_wrap%0d_out_sel", k), 64'(d3_out_sel), (k % 2 == 0) ? 64'd2 : 64'd0);
      chk($sformatf("n3_wrap%0d_out_data", k), 64'(d3_out_data), (k % 2 == 0) ? 64'hC2 : 64'hC0);
    end
    d3_in_valid = '0;

    // Randomized traffic against the model; producers hold until accepted
    do_reset();
    pend = '0;
    for (int c = 0; c < 400; c++) begin
      for (int ch = 0; ch < 4; ch++) begin
        if (!pend[ch]) begin
          in_valid[ch]          = ($urandom_range(0, 2) != 0);
          in_data[ch*16 +: 16]  = 16'($urandom);
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      er = model_ready(in_valid, out_ready);
      #3;
      chk($sformatf("rand%0d_in_ready", c), 64'(in_ready), 64'(er));
      model_step(in_valid, in_data, out_ready);
      pend = in_valid & ~er;
      @(posedge clk);
      #1;
      chk($sformatf("rand%0d_out_valid", c), 64'(out_valid), 64'(m_valid));
      chk($sformatf("rand%0d_out_data", c),  64'(out_data),  64'(m_data));
      chk($sformatf("rand%0d_out_sel", c),   64'(out_sel),   64'(m_sel));
    end
    in_valid = '0;

`ifdef HACK_ARB_MUX_FORCE_EN
    // Two round-robin transfers leave ptr at 2, then force channel 1
    do_reset();
    in_data   = d4;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("force_pre_out_sel", 64'(out_sel), 64'd1);
    f_en  = 1'b1;
    f_sel = 2'd1;
    for (int k = 0; k < 3; k++) begin
      #3;
      chk($sformatf("force%0d_in_ready", k), 64'(in_ready), 64'b0010);
      @(posedge clk);
      #1;
      chk($sformatf("force%0d_out_sel", k), 64'(out_sel), 64'd1);
    end
    f_en = 1'b0;
    #3;
    chk("force_release_in_ready", 64'(in_ready), 64'b0100);
    @(posedge clk);
    #1;
    chk("force_release_out_sel", 64'(out_sel), 64'd2);
    in_valid = '0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
